// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS control FSM and datapath strobes
module mips_mc_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t cur_state, nxt_state;
   logic   pc_write, branch, ir_w, mem_w, reg_w;

   always_ff @(posedge clk) begin
      if (rst) cur_state <= S_FETCH;
      else     cur_state <= nxt_state;
   end

   assign state = cur_state;

   always_comb begin
      nxt_state  = S_FETCH;
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_w       = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      iord       = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b010;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (cur_state)
         S_FETCH: begin
            alu_src_b = 2'b01;
            ir_w      = 1'b1;
            pc_write  = 1'b1;
            nxt_state = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_RTYPE:     nxt_state = S_EXECUTE;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_ADDI:      nxt_state = S_ADDIEXEC;
               OP_J:         nxt_state = S_JUMP;
               default: begin
                  nxt_state = S_FETCH;
                  illegal   = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            iord      = 1'b1;
            nxt_state = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_w      = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            iord       = 1'b1;
            mem_w      = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            nxt_state = S_ALUWB;
            // An unknown funct still retires as an add in ALUWB.
            case (funct)
               6'b100000: alu_ctrl = 3'b010;
               6'b100010: alu_ctrl = 3'b110;
               6'b100100: alu_ctrl = 3'b000;
               6'b100101: alu_ctrl = 3'b001;
               6'b101010: alu_ctrl = 3'b111;
               default:   illegal  = 1'b1;
            endcase
         end
         S_ALUWB: begin
            reg_dst    = 1'b1;
            reg_w      = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_ctrl   = 3'b110;
            pc_src     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_w      = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: nxt_state = S_FETCH;
      endcase
   end

   // Reset blocks every architectural write in the same cycle it is raised.
   assign pc_en     = (pc_write | (branch & zero)) & ~rst;
   assign ir_write  = ir_w  & ~rst;
   assign mem_write = mem_w & ~rst;
   assign reg_write = reg_w & ~rst;

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit for the MIPS multicycle core. It holds the instruction-sequencing state machine and drives every datapath control strobe: PC enable, instruction-register write, memory address select, register-file write, and ALU operand/op selects. It consumes the opcode, funct and ALU zero flag returned by the datapath. It supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU result == 0, combinational from the datapath
- pc_en  out  1  PC load enable: pc_write | (branch & zero)
- ir_write  out  1  latch memory read data into the instruction register
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- mem_write  out  1  data memory write enable
- reg_write  out  1  register-file write enable
- reg_dst  out  1  RF write address: 0 = rt, 1 = rd
- mem_to_reg  out  1  RF write data: 0 = ALU-out, 1 = memory data register
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs register
- alu_src_b  out  2  ALU B: 00 = rt register, 01 = constant 4, 10 = sign_imm, 11 = sign_imm<<2
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  next PC: 00 = ALU result, 01 = ALU-out register, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE/EXECUTE on an unsupported opcode/funct
- state  out  4  current state encoding (debug)

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unreachable; if entered, go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: 100011/101011→MEMADR; 000000→EXECUTE; 000100→BRANCH; 001000→ADDIEXEC; 000010→JUMP; any other opcode→FETCH with illegal=1.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEXEC→ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP all →FETCH.
- Outputs are Moore (decoded from state only), except that pc_en also uses zero and alu_ctrl in EXECUTE uses funct.
- Default for every output is 0, except alu_ctrl=010.
- Per-state outputs (non-default only):
  - FETCH: alu_src_b=01, ir_write=1, pc_write=1.
  - DECODE: alu_src_b=11.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMREAD: iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1.
  - MEMWRITE: iord=1, mem_write=1, instr_done=1.
  - EXECUTE: alu_src_a=1, alu_ctrl from funct. Mapping: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010 with illegal=1.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1.
  - BRANCH: alu_src_a=1, alu_ctrl=110, pc_src=01, branch=1, instr_done=1.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10.
  - ADDIWB: reg_write=1, instr_done=1.
  - JUMP: pc_src=10, pc_write=1, instr_done=1.
- An illegal R-type funct still completes ALUWB as an add. Illegal opcodes retire with no architectural write.

## Timing
- Reset: while rst=1, pc_en, ir_write, mem_write and reg_write are forced to 0. The state becomes FETCH on the edge that samples rst=1.
- First FETCH outputs appear in the cycle after rst deasserts.
- Reset asserted mid-instruction (for example in MEMWRITE) forces mem_write=0 combinationally in that same cycle. State is FETCH on the next edge; there is no partial retire.
- opcode and funct are only sampled in DECODE/MEMADR/EXECUTE. They are stable then because ir_write is asserted only in FETCH.
- zero is sampled combinationally in BRANCH only.
- Instruction latency from FETCH to the next FETCH:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal opcode 2 cycles.
- instr_done is high exactly one cycle per instruction, never for illegal opcodes.

## Test plan
- Reset: hold rst 3 cycles while in MEMWRITE, then release. Required: mem_write=0 during reset; state=0 and ir_write=1 with pc_en=1 on the first post-reset cycle.
- lw then sw: opcode=100011, then 101011. Required: state sequence 0,1,2,3,4 then 0,1,2,5. iord=1 in states 3 and 5; reg_write only in 4; mem_write only in 5.
- R-type: opcode=0 with funct 100010, then 101010. Required: alu_ctrl=110, then 111, in EXECUTE. reg_dst=1 and reg_write=1 in ALUWB; 4 cycles each.
- beq: opcode=000100 with zero=1 → pc_en=1, pc_src=01 in BRANCH. With zero=0 → pc_en=0. Both return to FETCH after 3 cycles.
- addi and j: 001000 → states 0,1,9,10, with reg_dst=0 and alu_src_b=10 in state 9. 000010 → states 0,1,11, with pc_src=10 and pc_en=1.
- Illegal: opcode=111111 → illegal=1 in DECODE, next state FETCH, no write enables, no instr_done. funct=000000 → illegal=1 in EXECUTE, alu_ctrl=010.
